bit_count_scheduler: RTL and testbench
======================================

# bit_count_scheduler

Round-robin scheduler that shares one `bitCounter` popcount datapath among `NREQ` requesters. It arbitrates among pending requests and drives the counter's `in`/`start` handshake. It captures `count` on `done` and returns the result to the granted requester with a one-cycle acknowledge. A watchdog aborts jobs whose counter never reports completion. It sits between the switch/host front-ends and the single shared counter instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, at least 2.
- `WIDTH`, 8: data width; must match the counter's `width`.
- `OUTW`, 4: result width; must match the counter's `outWidth`.
- `TIMEOUT`, 2*WIDTH+4: maximum RUN cycles before abort.

Ports:
- `clk`  in  1: the block's single clock.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NREQ: per-requester request level. Held high until that requester's `ack`.
- `req_data`  in  NREQ*WIDTH: packed operands. Slice i is `[i*WIDTH +: WIDTH]`. Stable while `req[i]` is high.
- `ack`  out  NREQ: one-hot, one-cycle completion pulse.
- `result`  out  OUTW: popcount. Valid while `ack` is nonzero.
- `result_id`  out  $clog2(NREQ): index of the acknowledged requester.
- `err`  out  1: pulses together with `ack` when the job timed out.
- `busy`  out  1: high in every state except IDLE.
- `cnt_in`  out  WIDTH: to counter `in`.
- `cnt_start`  out  1: to counter `start`.
- `cnt_count`  in  OUTW: from counter `count`.
- `cnt_done`  in  1: from counter `done`.

## Operation
States: IDLE, ARM, RUN, DONE.
- **IDLE**
  - If `req` is nonzero, grant the first set bit at or after `ptr`, searching upward with wrap.
  - Register the grant index as `gid` and `req_data` slice `gid` into `cnt_in`, then go to ARM.
  - If `req` is zero, stay in IDLE.
- **ARM**
  - `cnt_start`=0 for exactly one cycle, so the counter (idle state) latches `cnt_in`.
  - Clear the watchdog and go to RUN.
- **RUN**
  - `cnt_start`=1 and the watchdog increments each cycle.
  - On `cnt_done`=1: latch `cnt_count` into `result`, clear the error flag, go to DONE.
  - Otherwise, when the watchdog reaches `TIMEOUT`-1: set `result`=0, set the error flag, go to DONE.
  - `cnt_done` is ignored in every state other than RUN.
- **DONE**
  - `cnt_start`=0, which releases the counter back to idle.
  - `ack[gid]`=1, `result_id`=`gid`, `err`=error flag.
  - `ptr` <= (`gid`+1) mod `NREQ`. Next state is IDLE.
- `cnt_in` is held constant from IDLE exit until the next grant.
- Requests that drop before being granted are ignored. No request is ever cancelled once granted.
- A requester's `req` may still be high in the cycle after its `ack`. That request is a new job, eligible at the next IDLE under round-robin order.
- Watchdog width: $clog2(TIMEOUT+1). Comparison is unsigned.

## Timing
- Reset values: state IDLE, `ptr`=0, `ack`=0, `err`=0, `busy`=0, `cnt_start`=0, `cnt_in`=0, `result`=0, `result_id`=0.
- Reset mid-job forces IDLE on the next edge. No `ack` is issued for the aborted job. The requester must re-request (its `req` is still high, so it is re-granted normally).
- Request to `cnt_start` rising: 2 cycles (IDLE to ARM, ARM to RUN).
- `cnt_done` sampled high in RUN to `ack`: 1 cycle.
- Minimum spacing between `ack` pulses: 4 cycles plus the counter's run time.
- `cnt_done`=1 and watchdog expiry in the same RUN cycle: `cnt_done` wins, so `err`=0 and the result is valid.
- Fairness: a continuously requesting client waits at most `NREQ`-1 jobs.
- `ack`, `result`, `result_id` and `err` are all registered outputs.

## Structure
- Shared package `bit_count_pkg`:
  - state enum `sched_state_t` {IDLE, ARM, RUN, DONE};
  - default constants `BC_WIDTH`=8 and `BC_OUTW`=4.
- Sub-module `rr_arbiter` (parameter `NREQ`):
  - inputs: `req`, `ptr`;
  - outputs: combinational one-hot `grant` and index `gidx`;
  - purely combinational.
- The scheduler owns the FSM, `ptr`, watchdog and output registers.
- The counter is instantiated outside the block, so the bench may substitute a stub.

## Test plan
- Single request: `req`=4'b0100, slice 2 = 8'b11010001 -> one `ack`=4'b0100 with `result`=4, `result_id`=2, `err`=0. `cnt_start` rises 2 cycles after `req`.
- All four requesting simultaneously after reset, data 8'hFF, 8'h00, 8'h0F, 8'h81 -> acks in order 0,1,2,3 with results 8, 0, 4, 2.
- Fairness: `req[0]` and `req[3]` held high for 6 jobs -> ack order 0,3,0,3,0,3.
- Operand 8'h00 -> `result`=0, `err`=0. `cnt_start` drops in DONE and the next job's ARM sees the counter idle.
- Stub counter with `cnt_done` stuck at 0 -> after exactly `TIMEOUT` RUN cycles: `ack` pulse, `err`=1, `result`=0. The next job proceeds normally.
- `reset` asserted during RUN -> next edge `busy`=0, `cnt_start`=0, no `ack`. The held `req` is regranted starting from `ptr`=0.

Source files
------------

// File: rtl/bit_count_pkg.sv
// Shared types and default sizes for the bit-count scheduler and its counter.
package bit_count_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    // Default operand and popcount widths of the shared counter
    localparam int BC_WIDTH = 8;
    localparam int BC_OUTW  = 4;

endpackage

// File: rtl/bit_count_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit at or
// above ptr, wrapping around to bit 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx
);

    int   w_idx;
    logic w_found;

    // Scan upward from ptr with wrap; the first requester seen wins
    always_comb begin
        grant   = '0;
        gidx    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                gidx         = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/bit_count_scheduler.sv
// Round-robin scheduler sharing one popcount counter among NREQ requesters.
// Counter handshake: cnt_in is latched by the counter while cnt_start is low;
// cnt_start high runs it until cnt_done; dropping cnt_start returns it to idle.
// Requester handshake: req[i] stays high with stable data until a one-cycle
// ack[i]; result/result_id/err are valid only in that ack cycle.
module bit_count_scheduler
    import bit_count_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = BC_WIDTH,
    parameter int OUTW    = BC_OUTW,
    parameter int TIMEOUT = 2 * WIDTH + 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            ack,
    output logic [OUTW-1:0]            result,
    output logic [$clog2(NREQ)-1:0]    result_id,
    output logic                       err,
    output logic                       busy,
    output logic [WIDTH-1:0]           cnt_in,
    output logic                       cnt_start,
    input  logic [OUTW-1:0]            cnt_count,
    input  logic                       cnt_done
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    sched_state_t     r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gid;
    logic [NREQ-1:0]  r_gnt_oh;
    logic [WDW-1:0]   r_wdog;
    logic [NREQ-1:0]  r_ack;
    logic [OUTW-1:0]  r_result;
    logic [IDW-1:0]   r_result_id;
    logic             r_err;
    logic             r_cnt_start;
    logic [WIDTH-1:0] r_cnt_in;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gidx;
    logic [IDW-1:0]   w_ptr_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .gidx  (w_gidx)
    );

    // Round-robin pointer moves just past the requester being served
    assign w_ptr_next = (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;

    // Scheduler FSM: grant, arm counter, run with watchdog, acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_gnt_oh    <= '0;
            r_wdog      <= '0;
            r_ack       <= '0;
            r_result    <= '0;
            r_result_id <= '0;
            r_err       <= 1'b0;
            r_cnt_start <= 1'b0;
            r_cnt_in    <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gid    <= w_gidx;
                        r_gnt_oh <= w_grant;
                        r_cnt_in <= req_data[w_gidx*WIDTH +: WIDTH];
                        r_state  <= ARM;
                    end
                end
                ARM: begin
                    // Counter spends this cycle idle and latches cnt_in
                    r_wdog      <= '0;
                    r_cnt_start <= 1'b1;
                    r_state     <= RUN;
                end
                RUN: begin
                    if (cnt_done) begin
                        // Completion wins over a watchdog expiry in the same cycle
                        r_result    <= cnt_count;
                        r_err       <= 1'b0;
                        r_ack       <= r_gnt_oh;
                        r_result_id <= r_gid;
                        r_cnt_start <= 1'b0;
                        r_state     <= DONE;
                    end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                        r_result    <= '0;
                        r_err       <= 1'b1;
                        r_ack       <= r_gnt_oh;
                        r_result_id <= r_gid;
                        r_cnt_start <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                DONE: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign result    = r_result;
    assign result_id = r_result_id;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);
    assign cnt_in    = r_cnt_in;
    assign cnt_start = r_cnt_start;

endmodule

// File: tb/tb_bit_count_scheduler.sv
// Bench for bit_count_scheduler: counter stub, job-level round-robin model,
// directed and randomized batches checked with immediate assertions.
module tb_bit_count_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int OUTW    = 4;
    localparam int TIMEOUT = 2 * WIDTH + 4;
    localparam int IDW     = 2;
    localparam int MAXJ    = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic [OUTW-1:0]       result;
    logic [IDW-1:0]        result_id;
    logic                  err;
    logic                  busy;
    logic [WIDTH-1:0]      cnt_in;
    logic                  cnt_start;
    logic [OUTW-1:0]       cnt_count = '0;
    logic                  cnt_done  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    bit_count_scheduler #(
        .NREQ(NREQ), .WIDTH(WIDTH), .OUTW(OUTW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .result(result), .result_id(result_id), .err(err),
        .busy(busy), .cnt_in(cnt_in), .cnt_start(cnt_start),
        .cnt_count(cnt_count), .cnt_done(cnt_done)
    );

    // ---------------- counter stub ----------------
    bit               stuck     = 1'b0;
    bit               rand_lat  = 1'b1;
    int               fixed_lat = 0;
    logic [WIDTH-1:0] st_op     = '0;
    int               st_cnt    = 0;
    int               st_lat    = 0;

    always @(posedge clk) begin
        if (cnt_start !== 1'b1) begin
            cnt_done <= 1'b0;
            st_op    <= cnt_in;
            st_cnt   <= 0;
            st_lat   <= rand_lat ? int'($urandom_range(0, 6)) : fixed_lat;
        end else if (!stuck && !cnt_done) begin
            if (st_cnt == st_lat) begin
                cnt_done  <= 1'b1;
                cnt_count <= OUTW'($countones(st_op));
            end else begin
                st_cnt <= st_cnt + 1;
            end
        end
    end

    // ---------------- job store and reference model ----------------
    logic [WIDTH-1:0] job_data [NREQ][MAXJ];
    int               job_cnt  [NREQ];
    int               job_head [NREQ];
    int               m_ptr;
    logic [6:0]       exp_q[$];   // {err, id[1:0], result[3:0]}

    function automatic int ones(logic [WIDTH-1:0] d);
        int n = 0;
        for (int b = 0; b < WIDTH; b++) n += (d[b] ? 1 : 0);
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_jobs();
        for (int i = 0; i < NREQ; i++) begin
            job_cnt[i]  = 0;
            job_head[i] = 0;
        end
    endtask

    task automatic add_job(int i, logic [WIDTH-1:0] d);
        job_data[i][job_cnt[i]] = d;
        job_cnt[i]++;
    endtask

    // Predict ack order: serve the next requester with work at/after m_ptr
    task automatic build_expect();
        int  h[NREQ];
        int  pick;
        bit  any;
        logic [IDW-1:0]  idv;
        logic [OUTW-1:0] rv;
        for (int i = 0; i < NREQ; i++) h[i] = job_head[i];
        do begin
            any  = 1'b0;
            pick = 0;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!any && h[i] < job_cnt[i]) begin
                    any  = 1'b1;
                    pick = i;
                end
            end
            if (any) begin
                idv = IDW'(pick);
                rv  = stuck ? '0 : OUTW'(ones(job_data[pick][h[pick]]));
                exp_q.push_back({stuck, idv, rv});
                h[pick]++;
                m_ptr = (pick + 1) % NREQ;
            end
        end while (any);
    endtask

    // ---------------- driver ----------------
    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            if (job_head[i] < job_cnt[i]) begin
                req[i] = 1'b1;
                req_data[i*WIDTH +: WIDTH] = job_data[i][job_head[i]];
            end else begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic run_batch(int budget);
        int         cyc  = 0;
        int         runc = 0;
        int         spur = 0;
        int         id;
        logic       pd   = 1'b0;
        logic [6:0] e;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                e  = exp_q.pop_front();
                id = int'(e[5:4]);
                chk("ack_onehot", 32'(ack), 32'(1) << id);
                chk("result_id", 32'(result_id), 32'(e[5:4]));
                chk("result", 32'(result), 32'(e[3:0]));
                chk("err", 32'(err), 32'(e[6]));
                if (stuck) chk("timeout_cycles", 32'(runc), 32'(TIMEOUT));
                else       chk("done_to_ack", 32'(pd), 32'(1));
                job_head[id]++;
                drive_req();
                runc = 0;
            end else if (cnt_start) begin
                runc++;
            end
            pd = cnt_done;
        end
        if (exp_q.size() > 0) begin
            chk("batch_budget_left", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        repeat (8) begin
            @(negedge clk);
            if (ack != '0) spur++;
        end
        chk("spurious_ack", 32'(spur), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int tot;
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        clear_jobs();
        m_ptr = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cnt_start", 32'(cnt_start), 32'(0));
        chk("rst_cnt_in", 32'(cnt_in), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_result_id", 32'(result_id), 32'(0));
        reset = 1'b0;

        // Single request on slot 2; cnt_start rises two cycles later
        add_job(2, 8'b1101_0001);
        build_expect();
        drive_req();
        @(negedge clk);
        chk("arm_start_low", 32'(cnt_start), 32'(0));
        chk("arm_busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("run_start_high", 32'(cnt_start), 32'(1));
        run_batch(200);

        // All four at once after reset
        do_reset();
        add_job(0, 8'hFF);
        add_job(1, 8'h00);
        add_job(2, 8'h0F);
        add_job(3, 8'h81);
        build_expect();
        drive_req();
        run_batch(400);

        // Fairness between slots 0 and 3
        for (int j = 0; j < 3; j++) begin
            add_job(0, WIDTH'($urandom));
            add_job(3, WIDTH'($urandom));
        end
        build_expect();
        drive_req();
        run_batch(600);

        // Zero operand followed by another job on the same slot
        add_job(1, 8'h00);
        add_job(1, 8'hFF);
        build_expect();
        drive_req();
        run_batch(300);

        // Random batches
        for (int b = 0; b < 5; b++) begin
            tot = 0;
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) add_job(i, WIDTH'($urandom));
                tot += n;
            end
            if (tot == 0) add_job(int'($urandom_range(0, NREQ - 1)), WIDTH'($urandom));
            build_expect();
            drive_req();
            run_batch(1500);
        end

        // Done arrives in the same RUN cycle the watchdog expires
        rand_lat  = 1'b0;
        fixed_lat = TIMEOUT - 2;
        add_job(3, 8'hA5);
        build_expect();
        drive_req();
        run_batch(200);
        rand_lat = 1'b1;

        // Counter never completes: watchdog abort, then a normal job
        stuck = 1'b1;
        add_job(1, 8'hFF);
        build_expect();
        drive_req();
        run_batch(200);
        stuck = 1'b0;
        add_job(1, 8'h3C);
        build_expect();
        drive_req();
        run_batch(200);

        // Reset during RUN: aborted job gets no ack, ptr restarts at 0
        do_reset();
        add_job(2, 8'h07);
        build_expect();
        drive_req();
        run_batch(200);
        add_job(0, WIDTH'($urandom));
        add_job(3, WIDTH'($urandom));
        drive_req();
        w = 0;
        while (cnt_start !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("reach_run", 32'(cnt_start), 32'(1));
        @(negedge clk);
        chk("no_ack_before_reset", 32'(ack), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_cnt_start", 32'(cnt_start), 32'(0));
        chk("midrst_ack", 32'(ack), 32'(0));
        reset = 1'b0;
        m_ptr = 0;
        build_expect();
        run_batch(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
